// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioning blocks.
package button_pkg;

    localparam int SYNC_DEPTH = 2;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PRESS_CHK   = 3'd1,
        PRESSED     = 3'd2,
        REPEAT      = 3'd3,
        RELEASE_CHK = 3'd4
    } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync2
    import button_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= '0;
        else     ff <= {ff[SYNC_DEPTH-2:0], d};
    end

    assign q = ff[SYNC_DEPTH-1];

endmodule

// File: rtl/button_pulse_gen.sv
// Synchronizes, debounces and auto-repeats a raw push-button into one-cycle pulses.
module button_pulse_gen
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES     = 50000,
    parameter int REPEAT_CYCLES   = 10000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse,
    output logic level,
    output logic held
);

    localparam logic             HOLD_EN = (HOLD_CYCLES != 0);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Value is irrelevant when auto-repeat is disabled; avoid a negative constant.
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_EN ? HOLD_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pulse_nxt, level_nxt, held_nxt;
    logic             btn_s;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
            level <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
            level <= level_nxt;
            held  <= held_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (btn_s) state_nxt = PRESS_CHK;
            end
            PRESS_CHK: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_MAX) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end
            end
            PRESSED: begin
                // Release is checked first so it beats a coincident hold expiry.
                if (!btn_s) begin
                    state_nxt = RELEASE_CHK;
                    cnt_nxt   = '0;
                end else if (HOLD_EN && cnt == HOLD_MAX) begin
                    state_nxt = REPEAT;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end
            end
            REPEAT: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_CHK;
                    cnt_nxt   = '0;
                end else if (cnt == REP_MAX) begin
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end
            end
            RELEASE_CHK: begin
                if (btn_s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_MAX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Status outputs follow the state being entered so they stay registered.
    assign level_nxt = (state_nxt == PRESSED) || (state_nxt == REPEAT) || (state_nxt == RELEASE_CHK);
    assign held_nxt  = (state_nxt == REPEAT);

endmodule

// File: tb/tb_button_pulse_gen.sv
// Scoreboard bench: two DUTs (auto-repeat on/off) against a run-length/timestamp model.
module tb_button_pulse_gen;

    localparam int D  = 4;
    localparam int H  = 20;
    localparam int R  = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic pulse_a, level_a, held_a;
    logic pulse_b, level_b, held_b;
    logic tog_b = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    button_pulse_gen #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .pulse(pulse_a), .level(level_a), .held(held_a)
    );

    button_pulse_gen #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(0), .REPEAT_CYCLES(R), .CNT_W(CW)) u_dut_nohold (
        .clk(clk), .rst(rst), .btn_in(btn_in), .pulse(pulse_b), .level(level_b), .held(held_b)
    );

    // Downstream toggle stage, enable tied high.
    always @(posedge clk) tog_b <= tog_b ^ pulse_b;

    // ---------------- reference model ----------------
    logic [5:0] exp_q[$];
    bit  h_old, h_new;
    int  edge_n;
    bit  m_lvl[2];
    int  m_one[2], m_zero[2], m_anchor[2];
    int  m_hold[2];
    int  presses_b;

    function automatic void model_reset();
        h_old = 0; h_new = 0;
        for (int i = 0; i < 2; i++) begin
            m_lvl[i] = 0; m_one[i] = 0; m_zero[i] = 0; m_anchor[i] = -1;
        end
    endfunction

    // Returns {pulse, level, held} after the upcoming edge for instance i.
    function automatic logic [2:0] model_inst(int i, bit bs);
        bit p = 0;
        bit hd;
        int el;
        m_one[i]  = bs ? m_one[i] + 1 : 0;
        m_zero[i] = bs ? 0 : m_zero[i] + 1;
        if (!m_lvl[i]) begin
            if (m_one[i] == D + 1) begin
                m_lvl[i] = 1; p = 1; m_anchor[i] = edge_n;
                if (i == 1) presses_b++;
            end
        end else if (!bs) begin
            m_anchor[i] = -1;
            if (m_zero[i] == D + 1) m_lvl[i] = 0;
        end else if (m_anchor[i] < 0) begin
            m_anchor[i] = edge_n;
        end else if (m_hold[i] != 0) begin
            el = edge_n - m_anchor[i];
            if (el >= m_hold[i] && (el - m_hold[i]) % R == 0) p = 1;
        end
        hd = m_lvl[i] && m_hold[i] != 0 && m_anchor[i] >= 0 && (edge_n - m_anchor[i]) >= m_hold[i];
        return {p, m_lvl[i], hd};
    endfunction

    task automatic drive(input bit r, input bit b);
        bit bs;
        logic [2:0] ea, eb;
        @(negedge clk);
        rst = r;
        btn_in = b;
        if (r) begin
            model_reset();
            ea = 3'b000; eb = 3'b000;
        end else begin
            bs = h_old; h_old = h_new; h_new = b;
            edge_n++;
            ea = model_inst(0, bs);
            eb = model_inst(1, bs);
        end
        exp_q.push_back({ea, eb});
    endtask

    task automatic seg(input int n, input bit r, input bit b);
        repeat (n) drive(r, b);
    endtask

    // ---------------- monitor ----------------
    task automatic cmp(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    initial begin
        logic [5:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("pulse_a", pulse_a, e[5]);
                cmp("level_a", level_a, e[4]);
                cmp("held_a",  held_a,  e[3]);
                cmp("pulse_b", pulse_b, e[2]);
                cmp("level_b", level_b, e[1]);
                cmp("held_b",  held_b,  e[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit b;
        m_hold[0] = H;
        m_hold[1] = 0;
        edge_n = 0;
        presses_b = 0;
        model_reset();

        seg(3, 1, 1);               // held through reset release
        seg(30, 0, 1);
        seg(12, 0, 0);
        seg(3, 0, 0);               // clean press
        seg(12, 0, 1);
        seg(15, 0, 0);
        seg(3, 0, 1);               // press bounce
        seg(10, 0, 0);
        seg(60, 0, 1);              // long hold with repeats
        seg(15, 0, 0);
        seg(15, 0, 1);              // release glitch while pressed
        seg(2, 0, 0);
        seg(40, 0, 1);
        seg(15, 0, 0);
        seg(4, 0, 1);               // reset mid-debounce
        seg(2, 1, 0);
        seg(10, 0, 0);
        seg(100, 0, 1);             // long hold for the no-repeat instance
        seg(15, 0, 0);

        b = 0;
        for (int k = 0; k < 60; k++) begin
            b = ~b;
            if ($urandom_range(0, 3) == 0) seg($urandom_range(20, 45), 0, b);
            else                           seg($urandom_range(1, 8), 0, b);
            if ($urandom_range(0, 30) == 0) seg($urandom_range(1, 3), 1, b);
        end
        seg(20, 0, 0);

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        checks++;
        if (tog_b !== presses_b[0]) begin
            errors++;
            $display("FAIL toggle_parity: got %b expected %b (%0d presses)", tog_b, presses_b[0], presses_b);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
